mcu_core_p: RTL and testbench



---
 rtl/mcu_pkg.sv | 59 +++++
 rtl/mcu_alu.sv | 28 ++
 rtl/mcu_core_p.sv | 182 ++++++++++++++++++
 tb/tb_mcu_core_p.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the mcu_core_p microcontroller: opcodes, control
// FSM states and instruction field extraction.
// Instruction layout, MSB first: op[4] | ri[RSEL_W] | rj[RSEL_W] | imm[rest].
package mcu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_MOVI  = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_ADDI  = 4'd10;
  localparam logic [3:0] OP_JMP   = 4'd11;
  localparam logic [3:0] OP_JZ    = 4'd12;
  localparam logic [3:0] OP_IN    = 4'd13;
  localparam logic [3:0] OP_OUT   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  // Instructions are zero-extended to this width before field extraction.
  localparam int unsigned INSN_MAX_W = 64;

  function automatic logic [3:0] insn_op(input logic [INSN_MAX_W-1:0] insn,
                                         input int unsigned data_w);
    return 4'(insn >> (data_w - 4));
  endfunction

  function automatic logic [3:0] insn_ri(input logic [INSN_MAX_W-1:0] insn,
                                         input int unsigned data_w,
                                         input int unsigned nregs);
    int unsigned rw;
    rw = $clog2(nregs);
    return 4'((insn >> (data_w - 4 - rw)) &
              ((INSN_MAX_W'(1) << rw) - INSN_MAX_W'(1)));
  endfunction

  function automatic logic [3:0] insn_rj(input logic [INSN_MAX_W-1:0] insn,
                                         input int unsigned data_w,
                                         input int unsigned nregs);
    int unsigned rw;
    rw = $clog2(nregs);
    return 4'((insn >> (data_w - 4 - 2 * rw)) &
              ((INSN_MAX_W'(1) << rw) - INSN_MAX_W'(1)));
  endfunction

  function automatic logic [INSN_MAX_W-1:0] insn_imm(input logic [INSN_MAX_W-1:0] insn,
                                                     input int unsigned data_w,
                                                     input int unsigned nregs);
    int unsigned imm_w;
    imm_w = data_w - 4 - 2 * $clog2(nregs);
    return insn & ((INSN_MAX_W'(1) << imm_w) - INSN_MAX_W'(1));
  endfunction

endpackage

// File: rtl/mcu_alu.sv
// Combinational ALU for the register-register and add-immediate opcodes.
// Ports: a, b operands; op opcode; result DATA_W bits (wraps); zero = result==0.
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB:          result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      default:         result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mcu_core_p.sv
// Single-bus microcontroller core: register file, ALU, pc, one shared memory
// port with req/ack handshake, I/O ports, driven by a FETCH/EXEC/MEM/HALT FSM.
// Ports: clk, rst (sync, active-high); mem_en/mem_we/mem_addr/mem_wdata request
// (registered); mem_rdata/mem_ack response; port_in sampled by IN; port_out
// written by OUT; halted set once HALT executes.
module mcu_core_p
  import mcu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] port_in,
  output logic [DATA_W-1:0] port_out,
  output logic              halted
);

  localparam int unsigned RSEL_W = $clog2(NREGS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic                z_q, z_d;
  logic [DATA_W-1:0]   port_out_q, port_out_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                halted_q, halted_d;

  // Decode of the held instruction
  logic [INSN_MAX_W-1:0] ir_ext;
  logic [3:0]            op;
  logic [RSEL_W-1:0]     ri, rj;
  logic [DATA_W-1:0]     imm, ri_val, rj_val, alu_b, alu_res;
  logic                  alu_zero;

  assign ir_ext = INSN_MAX_W'(ir_q);
  assign op     = insn_op(ir_ext, DATA_W);
  assign ri     = RSEL_W'(insn_ri(ir_ext, DATA_W, NREGS));
  assign rj     = RSEL_W'(insn_rj(ir_ext, DATA_W, NREGS));
  assign imm    = DATA_W'(insn_imm(ir_ext, DATA_W, NREGS));
  assign ri_val = regs_q[ri];
  assign rj_val = regs_q[rj];
  assign alu_b  = (op == OP_ADDI) ? imm : rj_val;

  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (ri_val),
    .b      (alu_b),
    .op     (op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Next-state and request logic; request fields only change when a new
  // request is issued, so they stay stable across wait cycles.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    z_d         = z_q;
    port_out_d  = port_out_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;

    case (state_q)
      FETCH: begin
        if (!mem_en_q) begin
          // First fetch after reset: raise the request
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem_ack) begin
          ir_d     = mem_rdata;
          pc_d     = pc_q + ADDR_W'(1);
          mem_en_d = 1'b0;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        case (op)
          OP_MOV:   regs_d[ri] = rj_val;
          OP_MOVI:  regs_d[ri] = imm;
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
            regs_d[ri] = alu_res;
            z_d        = alu_zero;
          end
          OP_JMP:   pc_d = ADDR_W'(imm);
          OP_JZ:    if (z_q) pc_d = ADDR_W'(imm);
          OP_IN:    regs_d[ri] = port_in;
          OP_OUT:   port_out_d = ri_val;
          OP_HALT:  state_d = HALT;
          default:  ;
        endcase

        if (state_d == MEM) begin
          mem_en_d    = 1'b1;
          mem_we_d    = (op == OP_STORE);
          mem_addr_d  = ADDR_W'(rj_val);
          mem_wdata_d = ri_val;
        end else if (state_d == FETCH) begin
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_d;
        end else begin
          halted_d = 1'b1;
        end
      end

      MEM: begin
        if (mem_ack) begin
          if (!mem_we_q) regs_d[ri] = mem_rdata;
          state_d    = FETCH;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end
      end

      HALT: begin
        mem_en_d = 1'b0;
        halted_d = 1'b1;
      end

      default: state_d = FETCH;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      regs_q      <= '{default: '0};
      z_q         <= 1'b0;
      port_out_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      z_q         <= z_d;
      port_out_q  <= port_out_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign port_out  = port_out_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mcu_core_p.sv
// Directed bench for mcu_core_p with a behavioural memory (per-region waits).
module tb_mcu_core_p;
  import mcu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en, mem_we, halted;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, port_out;
  logic [15:0] mem_rdata = '0;
  logic [15:0] port_in = '0;

  logic [15:0] mem [256];
  int          ack_cyc [256];
  int          fetch_wait = 0, data_wait = 0, stall_addr = -1;
  int          wcnt = 0, cyc = 0, need = 0;
  logic        pend = 1'b0;
  logic [25:0] snap = '0;
  int          n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  mcu_core_p #(.DATA_W(16), .NREGS(4), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .port_in   (port_in),
    .port_out  (port_out),
    .halted    (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input int ri, input int rj, input int imm);
    return {op, 2'(ri), 2'(rj), 8'(imm)};
  endfunction

  // Memory response and request-stability monitor (evaluated on negedge)
  always @(negedge clk) begin
    cyc++;
    if (mem_en && (int'(mem_addr) == stall_addr)) need = 1000;
    else if (mem_addr >= 8'h10)                   need = data_wait;
    else                                          need = fetch_wait;
    mem_ack   = mem_en && (wcnt >= need);
    mem_rdata = mem[mem_addr];
    if (rst) pend = 1'b0;
    else begin
      if (pend) check_eq("req_stable", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'(snap));
      pend = mem_en && !mem_ack;
      snap = {mem_en, mem_we, mem_addr, mem_wdata};
      if (mem_en && mem_ack && !mem_we) ack_cyc[mem_addr] = cyc;
    end
  end

  always @(posedge clk) begin
    if (rst || !mem_en) wcnt = 0;
    else if (mem_ack) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wcnt = 0;
    end else wcnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000;
      ack_cyc[i] = -1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    step();
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_pc", 32'(dut.pc_q), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      step();
      n++;
    end
    check_eq("halt_seen", 32'(halted), 32'd1);
  endtask

  task automatic wait_ack(input int a, input int budget);
    int n;
    n = 0;
    while (ack_cyc[a] < 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("ack_seen", 32'(ack_cyc[a] >= 0), 32'd1);
  endtask

  initial begin
    int c;
    int c_out;

    // Reset state, MOVI, HALT timing counted from the first request cycle
    clear_mem();
    mem[0] = enc(OP_MOVI, 2, 0, 5);
    mem[1] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_port_out", 32'(port_out), 32'd0);
    c = 0;
    while (!mem_en && c < 10) begin step(); c++; end
    c = 0;
    while (!halted && c < 20) begin step(); c++; end
    check_eq("halt_cycle", 32'(c), 32'd4);
    check_eq("movi_r2", 32'(dut.regs_q[2]), 32'd5);
    check_eq("halt_pc", 32'(dut.pc_q), 32'd2);
    step();
    check_eq("halt_mem_en", 32'(mem_en), 32'd0);

    // SUB to zero, taken JZ skips address 3
    clear_mem();
    mem[0] = enc(OP_MOVI, 1, 0, 3);
    mem[1] = enc(OP_SUB, 1, 1, 0);
    mem[2] = enc(OP_JZ, 0, 0, 6);
    mem[3] = enc(OP_MOVI, 3, 0, 8'h55);
    mem[4] = enc(OP_HALT, 0, 0, 0);
    mem[6] = enc(OP_OUT, 1, 0, 0);
    mem[7] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_halt(100);
    check_eq("jz_port_out", 32'(port_out), 32'd0);
    check_eq("jz_z", 32'(dut.z_q), 32'd1);
    check_eq("jz_skip_r3", 32'(dut.regs_q[3]), 32'd0);
    check_eq("jz_pc", 32'(dut.pc_q), 32'd8);

    // STORE/LOAD with three wait cycles on data accesses
    clear_mem();
    data_wait = 3;
    mem[0] = enc(OP_MOVI, 0, 0, 8'h20);
    mem[1] = enc(OP_MOVI, 3, 0, 8'hAB);
    mem[2] = enc(OP_STORE, 3, 0, 0);
    mem[3] = enc(OP_LOAD, 1, 0, 0);
    mem[4] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_halt(200);
    check_eq("store_mem20", 32'(mem[8'h20]), 32'h00AB);
    check_eq("load_r1", 32'(dut.regs_q[1]), 32'h00AB);
    check_eq("store_cycles", 32'(ack_cyc[3] - ack_cyc[2]), 32'd6);
    check_eq("load_cycles", 32'(ack_cyc[4] - ack_cyc[3]), 32'd6);
    data_wait = 0;

    // 0xFFFF + 1 wraps to 0 with z; pc wraps 0xFF -> 0x00
    clear_mem();
    mem[0]     = enc(OP_MOVI, 1, 0, 1);
    mem[1]     = enc(OP_SUB, 0, 1, 0);
    mem[2]     = enc(OP_ADDI, 0, 0, 1);
    mem[3]     = enc(OP_JMP, 0, 0, 8'hFF);
    mem[8'hFF] = enc(OP_NOP, 0, 0, 0);
    do_reset();
    wait_ack(255, 100);
    check_eq("addi_wrap_r0", 32'(dut.regs_q[0]), 32'd0);
    check_eq("addi_wrap_z", 32'(dut.z_q), 32'd1);
    step();
    check_eq("pc_wrap", 32'(dut.pc_q), 32'd0);
    step();
    check_eq("wrap_fetch_en", 32'(mem_en), 32'd1);
    check_eq("wrap_fetch_addr", 32'(mem_addr), 32'd0);

    // IN then OUT: port_out updates two cycles after OUT's fetch
    clear_mem();
    port_in = 16'h1234;
    mem[0] = enc(OP_IN, 2, 0, 0);
    mem[1] = enc(OP_OUT, 2, 0, 0);
    mem[2] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_ack(1, 50);
    c_out = ack_cyc[1];
    step();
    check_eq("out_not_yet", 32'(port_out), 32'd0);
    step();
    check_eq("out_port", 32'(port_out), 32'h1234);
    check_eq("out_timing", 32'(cyc - c_out), 32'd2);

    // Reset while a fetch is outstanding
    clear_mem();
    stall_addr = 2;
    mem[0] = enc(OP_MOVI, 1, 0, 7);
    mem[1] = enc(OP_NOP, 0, 0, 0);
    mem[2] = enc(OP_MOVI, 2, 0, 9);
    mem[3] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    c = 0;
    while (!(mem_en && mem_addr == 8'd2) && c < 50) begin step(); c++; end
    step();
    check_eq("stall_pc", 32'(dut.pc_q), 32'd2);
    check_eq("stall_r1", 32'(dut.regs_q[1]), 32'd7);
    rst = 1'b1;
    step();
    check_eq("midrst_mem_en", 32'(mem_en), 32'd0);
    check_eq("midrst_pc", 32'(dut.pc_q), 32'd0);
    check_eq("midrst_r1", 32'(dut.regs_q[1]), 32'd0);
    rst = 1'b0;
    stall_addr = -1;
    step();
    check_eq("restart_en", 32'(mem_en), 32'd1);
    check_eq("restart_addr", 32'(mem_addr), 32'd0);
    wait_halt(100);
    check_eq("restart_r2", 32'(dut.regs_q[2]), 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
